apb_slave_regs14: RTL and testbench

APB_SLAVE_REGS14 -- requirements
Module: apb_slave_regs14

---
 rtl/apb_slave_regs14.sv | 207 ++++++++++++++++++++
 tb/tb_apb_slave_regs14.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regs14.sv
// ---------------------------------------------------------------------------
// apb_slave_regs14
//
// APB slave in front of a small bank of read/write registers. A transfer is
// tracked by a three-state FSM (IDLE -> SETUP -> ACCESS). The address, the
// direction and the write data are captured when the setup phase is seen.
// The response is stretched by a programmable number of wait states. Bus
// protocol violations are flagged with a sticky bit and counted in a
// saturating counter.
//
// Parameters
//   PADDR_WIDTH14  address bus width
//   PDATA_WIDTH14  data width (8, 16 or 32)
//   NUM_REGS14     number of registers in the bank (1..256)
//   MAX_WAIT14     upper bound on wait states (0..15)
//
// Ports
//   pclock14    in   APB clock, rising edge
//   preset14    in   asynchronous active-low reset
//   paddr14     in   byte address
//   prwd14      in   1 = write, 0 = read
//   pwdata14    in   write data
//   psel14      in   slave select
//   penable14   in   access phase
//   wait_cfg14  in   wait states per transfer, clamped to MAX_WAIT14
//   prdata14    out  read data, zero outside the completing read cycle
//   pready14    out  transfer complete
//   pslverr14   out  error response for an out-of-range index
//   prot_err14  out  sticky protocol-violation flag
//   err_cnt14   out  saturating protocol-violation count
// ---------------------------------------------------------------------------
module apb_slave_regs14 #(
    parameter int PADDR_WIDTH14 = 32,
    parameter int PDATA_WIDTH14 = 32,
    parameter int NUM_REGS14    = 16,
    parameter int MAX_WAIT14    = 15
) (
    input  logic                     pclock14,
    input  logic                     preset14,
    input  logic [PADDR_WIDTH14-1:0] paddr14,
    input  logic                     prwd14,
    input  logic [PDATA_WIDTH14-1:0] pwdata14,
    input  logic                     psel14,
    input  logic                     penable14,
    input  logic [3:0]               wait_cfg14,
    output logic [PDATA_WIDTH14-1:0] prdata14,
    output logic                     pready14,
    output logic                     pslverr14,
    output logic                     prot_err14,
    output logic [7:0]               err_cnt14
);

    // Byte-offset bits dropped from the address to form the register index.
    localparam int IDX_SHIFT = $clog2(PDATA_WIDTH14 / 8);
    localparam int IDX_BITS  = (NUM_REGS14 > 1) ? $clog2(NUM_REGS14) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [PADDR_WIDTH14-1:0] addr_q;
    logic                     wr_q;
    logic [PDATA_WIDTH14-1:0] wdata_q;
    logic [3:0]               cnt_q;
    logic [PDATA_WIDTH14-1:0] regs [NUM_REGS14];
    logic                     prot_err_q;
    logic [7:0]               err_cnt_q;

    logic [PADDR_WIDTH14-1:0] idx;
    logic [IDX_BITS-1:0]      reg_sel;
    logic                     in_range;
    logic [3:0]               wait_clamped;
    logic                     setup_take;
    logic                     do_write;
    logic                     viol;

    // The index and the range check come from the latched address. As a
    // result, every response output depends only on flops.
    assign idx      = addr_q >> IDX_SHIFT;
    assign reg_sel  = idx[IDX_BITS-1:0];
    assign in_range = (idx < PADDR_WIDTH14'(NUM_REGS14));

    // The wait count is limited to what the configuration allows.
    always_comb begin
        wait_clamped = wait_cfg14;
        if (wait_cfg14 > 4'(MAX_WAIT14)) begin
            wait_clamped = 4'(MAX_WAIT14);
        end
    end

    // A new transfer is accepted whenever the FSM is idle and the bus shows
    // a setup phase. This includes the cycle right after a completion, so
    // back-to-back transfers need no idle cycle.
    assign setup_take = (state_q == IDLE) && psel14 && !penable14;

    assign pready14  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign pslverr14 = pready14 && !in_range;
    assign prdata14  = (pready14 && !wr_q && in_range) ? regs[reg_sel] : '0;

    // A write commits only on the completing edge. If the master has
    // already dropped psel, the transfer is treated as abandoned.
    assign do_write = pready14 && psel14 && wr_q && in_range;

    // FSM state register.
    always_ff @(posedge pclock14 or negedge preset14) begin
        if (!preset14) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. When psel drops in ACCESS, the transfer is aborted
    // and the FSM returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup_take) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready14 || !psel14) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the transfer attributes in the setup phase. The wait counter
    // then runs down to zero while the FSM is in ACCESS.
    always_ff @(posedge pclock14 or negedge preset14) begin
        if (!preset14) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
        end else if (setup_take) begin
            addr_q  <= paddr14;
            wr_q    <= prwd14;
            wdata_q <= pwdata14;
            cnt_q   <= wait_clamped;
        end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Register bank.
    always_ff @(posedge pclock14 or negedge preset14) begin
        if (!preset14) begin
            for (int i = 0; i < NUM_REGS14; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[reg_sel] <= wdata_q;
        end
    end

    // Protocol violations:
    // - penable high while idle;
    // - the master dropping psel, or changing the address, direction or
    //   data, while the slave is still inserting wait states;
    // - a fresh setup phase while an access is in progress.
    // These are OR-ed together, so one cycle counts at most once.
    always_comb begin
        viol = 1'b0;
        if ((state_q == IDLE) && penable14) begin
            viol = 1'b1;
        end
        if ((state_q == ACCESS) && !pready14 &&
            (!psel14 || (paddr14 != addr_q) || (prwd14 != wr_q) ||
             (pwdata14 != wdata_q))) begin
            viol = 1'b1;
        end
        if ((state_q == ACCESS) && psel14 && !penable14) begin
            viol = 1'b1;
        end
    end

    // The flag is sticky. The counter saturates at all ones.
    always_ff @(posedge pclock14 or negedge preset14) begin
        if (!preset14) begin
            prot_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else if (viol) begin
            prot_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign prot_err14 = prot_err_q;
    assign err_cnt14  = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_regs14.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regs14
//
// Self-checking bench for apb_slave_regs14 with the default parameters.
// Each transfer pushes its expected response into a scoreboard queue. The
// entry is popped and compared when the slave raises pready14. A simple
// array of registers holds the expected bank contents.
// ---------------------------------------------------------------------------
module tb_apb_slave_regs14;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic          pclock14 = 1'b0;
    logic          preset14;
    logic [AW-1:0] paddr14;
    logic          prwd14;
    logic [DW-1:0] pwdata14;
    logic          psel14;
    logic          penable14;
    logic [3:0]    wait_cfg14;
    logic [DW-1:0] prdata14;
    logic          pready14;
    logic          pslverr14;
    logic          prot_err14;
    logic [7:0]    err_cnt14;

    int vecCount  = 0;
    int missCount = 0;

    logic [31:0] model [NR];

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chkData;
        int          lows;
        string       tag;
    } exp_t;

    exp_t sb[$];

    apb_slave_regs14 #(
        .PADDR_WIDTH14(AW),
        .PDATA_WIDTH14(DW),
        .NUM_REGS14(NR),
        .MAX_WAIT14(15)
    ) dut (
        .pclock14(pclock14),
        .preset14(preset14),
        .paddr14(paddr14),
        .prwd14(prwd14),
        .pwdata14(pwdata14),
        .psel14(psel14),
        .penable14(penable14),
        .wait_cfg14(wait_cfg14),
        .prdata14(prdata14),
        .pready14(pready14),
        .pslverr14(pslverr14),
        .prot_err14(prot_err14),
        .err_cnt14(err_cnt14)
    );

    always #5 pclock14 = ~pclock14;

    // Count one comparison and report it if it misses.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic goIdle();
        psel14    = 1'b0;
        penable14 = 1'b0;
    endtask

    // One full APB transfer. The task is entered and left 1 time unit after
    // a rising edge. On exit the bus still shows the completed access, so
    // the caller can either go idle or start the next setup at once.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic wr, input logic [31:0] data,
                                 input logic [3:0] waits);
        exp_t e;
        int   idx;
        int   lows;
        bit   done;
        idx       = int'(addr >> 2);
        e.tag     = tag;
        e.err     = (idx >= NR);
        e.chkData = !wr;
        e.lows    = int'(waits) + 1;
        e.data    = (!wr && idx < NR) ? model[idx] : 32'h0;
        if (wr && idx < NR) begin
            model[idx] = data;
        end
        sb.push_back(e);

        paddr14    = addr;
        prwd14     = wr;
        pwdata14   = data;
        wait_cfg14 = waits;
        psel14     = 1'b1;
        penable14  = 1'b0;
        @(posedge pclock14);
        #1 penable14 = 1'b1;

        lows = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge pclock14);
            if (pready14) begin
                e = sb.pop_front();
                checkOutput({e.tag, "_lows"}, 64'(lows), 64'(e.lows));
                checkOutput({e.tag, "_slverr"}, 64'(pslverr14), 64'(e.err));
                if (e.chkData) begin
                    checkOutput({e.tag, "_rdata"}, 64'(prdata14), 64'(e.data));
                end
                done = 1'b1;
            end else begin
                lows++;
                checkOutput({tag, "_waitout"}, {31'b0, pslverr14, prdata14}, 64'h0);
            end
            @(posedge pclock14);
            #1;
        end
        if (!done) begin
            checkOutput({tag, "_timeout"}, 64'h0, 64'h1);
            e = sb.pop_front();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] raddr;
        bit          done;

        for (int i = 0; i < NR; i++) begin
            model[i] = 32'h0;
        end
        preset14   = 1'b0;
        paddr14    = '0;
        prwd14     = 1'b0;
        pwdata14   = '0;
        psel14     = 1'b0;
        penable14  = 1'b0;
        wait_cfg14 = 4'd0;

        // Reset state.
        repeat (3) @(posedge pclock14);
        #1;
        checkOutput("rst_pready", 64'(pready14), 64'h0);
        checkOutput("rst_pslverr", 64'(pslverr14), 64'h0);
        checkOutput("rst_prdata", 64'(prdata14), 64'h0);
        checkOutput("rst_prot_err", 64'(prot_err14), 64'h0);
        checkOutput("rst_err_cnt", 64'(err_cnt14), 64'h0);
        preset14 = 1'b1;

        // Zero-wait write, then read back.
        applyStimulus("zw_wr", 32'h08, 1'b1, 32'hA5A5_0001, 4'd0);
        goIdle();
        @(posedge pclock14); #1;
        applyStimulus("zw_rd", 32'h08, 1'b0, 32'h0, 4'd0);
        goIdle();

        // Three wait states.
        applyStimulus("ws3_rd", 32'h00, 1'b0, 32'h0, 4'd3);
        goIdle();

        // Out-of-range write and read, then sweep the bank to confirm that
        // nothing changed.
        applyStimulus("oor_wr", 32'h40, 1'b1, 32'hFFFF_FFFF, 4'd1);
        goIdle();
        applyStimulus("oor_rd", 32'h40, 1'b0, 32'h0, 4'd0);
        goIdle();
        for (int i = 0; i < NR; i++) begin
            applyStimulus($sformatf("sweep%0d", i), 32'(i * 4), 1'b0, 32'h0, 4'd0);
            goIdle();
        end

        // Back-to-back writes, then read back.
        applyStimulus("b2b_wr0", 32'h0C, 1'b1, 32'h1111_0C0C, 4'd1);
        applyStimulus("b2b_wr1", 32'h10, 1'b1, 32'h2222_1010, 4'd0);
        applyStimulus("b2b_wr2", 32'h14, 1'b1, 32'h3333_1414, 4'd2);
        goIdle();
        applyStimulus("b2b_rd0", 32'h0C, 1'b0, 32'h0, 4'd0);
        applyStimulus("b2b_rd1", 32'h10, 1'b0, 32'h0, 4'd0);
        applyStimulus("b2b_rd2", 32'h14, 1'b0, 32'h0, 4'd0);
        goIdle();
        @(negedge pclock14);
        checkOutput("b2b_err_cnt", 64'(err_cnt14), 64'h0);
        checkOutput("b2b_prot_err", 64'(prot_err14), 64'h0);
        @(posedge pclock14); #1;

        // Random mix. The address includes random byte-offset bits and
        // sometimes goes past the end of the bank.
        for (int i = 0; i < 24; i++) begin
            raddr = {$urandom_range(0, 19), 2'($urandom_range(0, 3))};
            applyStimulus($sformatf("rnd%0d", i), raddr, 1'($urandom_range(0, 1)),
                          $urandom, 4'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 0) begin
                goIdle();
                @(posedge pclock14); #1;
            end
        end
        goIdle();
        @(posedge pclock14); #1;

        // Protocol errors. First, penable is high while idle.
        penable14 = 1'b1;
        @(posedge pclock14); #1;
        penable14 = 1'b0;
        // Second, paddr changes for one wait-state cycle.
        paddr14    = 32'h00;
        prwd14     = 1'b0;
        wait_cfg14 = 4'd3;
        psel14     = 1'b1;
        @(posedge pclock14); #1;
        penable14 = 1'b1;
        @(posedge pclock14); #1;
        paddr14 = 32'h04;
        @(posedge pclock14); #1;
        paddr14 = 32'h00;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge pclock14);
            done = pready14;
            @(posedge pclock14); #1;
        end
        if (!done) begin
            checkOutput("perr_timeout", 64'h0, 64'h1);
        end
        goIdle();
        @(negedge pclock14);
        checkOutput("perr_flag", 64'(prot_err14), 64'h1);
        checkOutput("perr_cnt2", 64'(err_cnt14), 64'd2);
        @(posedge pclock14); #1;
        penable14 = 1'b1;
        repeat (300) @(posedge pclock14);
        #1 penable14 = 1'b0;
        @(negedge pclock14);
        checkOutput("perr_sat", 64'(err_cnt14), 64'd255);
        @(posedge pclock14); #1;

        // Reset in the second access cycle of a long write.
        paddr14    = 32'h04;
        prwd14     = 1'b1;
        pwdata14   = 32'h1234;
        wait_cfg14 = 4'd5;
        psel14     = 1'b1;
        penable14  = 1'b0;
        @(posedge pclock14); #1;
        penable14 = 1'b1;
        @(posedge pclock14); #1;
        @(posedge pclock14); #1;
        preset14 = 1'b0;
        #1;
        checkOutput("mrst_pready", 64'(pready14), 64'h0);
        checkOutput("mrst_prdata", 64'(prdata14), 64'h0);
        checkOutput("mrst_pslverr", 64'(pslverr14), 64'h0);
        checkOutput("mrst_prot_err", 64'(prot_err14), 64'h0);
        checkOutput("mrst_err_cnt", 64'(err_cnt14), 64'h0);
        goIdle();
        for (int i = 0; i < NR; i++) begin
            model[i] = 32'h0;
        end
        @(posedge pclock14); #1;
        preset14 = 1'b1;
        applyStimulus("mrst_rd04", 32'h04, 1'b0, 32'h0, 4'd0);
        goIdle();
        applyStimulus("mrst_rd08", 32'h08, 1'b0, 32'h0, 4'd1);
        goIdle();
        @(negedge pclock14);
        checkOutput("final_err_cnt", 64'(err_cnt14), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
